sram_responder: RTL and testbench

- Clocked, synthesizable responder model of the 256K x 16 asynchronous SRAM that the SRAM controller drives.
- Sits at the pin side of the controller in simulation and FPGA loopback builds, replacing the off-chip device.
- Stores data in a reduced-depth array and models byte masks, read latency and DQ turnaround.
- Exposes access counters and a sticky contention flag for the bench.

---
 rtl/sram_responder.sv | 128 ++++++++++++
 tb/tb_sram_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Clocked stand-in for the 256K x 16 asynchronous SRAM on the controller pins.
// Reduced-depth array with byte masks, read latency, DQ turnaround and bench counters.
module sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [15:0]      SRAM_DQ,
    input  logic [17:0]      SRAM_ADDR,
    input  logic             SRAM_UB_N,
    input  logic             SRAM_LB_N,
    input  logic             SRAM_WE_N,
    input  logic             SRAM_CE_N,
    input  logic             SRAM_OE_N,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic             contention
);

    localparam int unsigned WORDS      = 2 ** DEPTH_LOG2;
    localparam logic [2:0]  LAT_RELOAD = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

    logic [15:0]           mem [WORDS];
    state_t                state, state_nx;
    logic [17:0]           cap_addr, cap_addr_nx;
    logic [2:0]            lat_cnt, lat_cnt_nx;
    logic                  rd_enter;
    logic                  sel, wr_cyc, rd_cyc, wr_any;
    logic [15:0]           rdata;
    logic                  drv_hi, drv_lo;

    assign sel    = !SRAM_CE_N;
    assign wr_cyc = sel && !SRAM_WE_N;
    assign rd_cyc = sel && SRAM_WE_N && !SRAM_OE_N;
    assign wr_any = wr_cyc && (!SRAM_UB_N || !SRAM_LB_N);

    always_comb begin
        state_nx    = state;
        cap_addr_nx = cap_addr;
        lat_cnt_nx  = lat_cnt;
        rd_enter    = 1'b0;
        if (wr_cyc) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_cyc) begin
                        cap_addr_nx = SRAM_ADDR;
                        lat_cnt_nx  = LAT_RELOAD;
                        if (READ_LAT == 1) begin
                            state_nx = DRIVE;
                            rd_enter = 1'b1;
                        end else begin
                            state_nx = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!rd_cyc) begin
                        state_nx = IDLE;
                    end else if (SRAM_ADDR != cap_addr) begin
                        cap_addr_nx = SRAM_ADDR;
                        lat_cnt_nx  = LAT_RELOAD;
                    end else begin
                        // Counter reaches zero on this edge, so DRIVE begins right after it
                        lat_cnt_nx = lat_cnt - 3'd1;
                        if (lat_cnt == 3'd1) begin
                            state_nx = DRIVE;
                            rd_enter = 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (!rd_cyc) begin
                        state_nx = IDLE;
                    end else if (SRAM_ADDR != cap_addr) begin
                        cap_addr_nx = SRAM_ADDR;
                        lat_cnt_nx  = LAT_RELOAD;
                        if (READ_LAT == 1) begin
                            rd_enter = 1'b1;
                        end else begin
                            state_nx = WAIT;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cap_addr   <= '0;
            lat_cnt    <= '0;
            wr_count   <= '0;
            rd_count   <= '0;
            contention <= 1'b0;
        end else begin
            state    <= state_nx;
            cap_addr <= cap_addr_nx;
            lat_cnt  <= lat_cnt_nx;
            if (wr_any && wr_count != '1) wr_count <= wr_count + CNT_W'(1);
            if (rd_enter && rd_count != '1) rd_count <= rd_count + CNT_W'(1);
            if (sel && !SRAM_WE_N && !SRAM_OE_N) contention <= 1'b1;
        end
    end

    // Array has no reset: contents survive rst like the real device
    always_ff @(posedge clk) begin
        if (wr_cyc) begin
            if (!SRAM_UB_N) mem[SRAM_ADDR[DEPTH_LOG2-1:0]][15:8] <= SRAM_DQ[15:8];
            if (!SRAM_LB_N) mem[SRAM_ADDR[DEPTH_LOG2-1:0]][7:0]  <= SRAM_DQ[7:0];
        end
    end

    assign rdata  = mem[cap_addr[DEPTH_LOG2-1:0]];
    assign drv_hi = (state == DRIVE) && rd_cyc && !SRAM_UB_N;
    assign drv_lo = (state == DRIVE) && rd_cyc && !SRAM_LB_N;

    assign SRAM_DQ[15:8] = drv_hi ? rdata[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = drv_lo ? rdata[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (latency 1 / 16-bit counters, latency 3 / 4-bit counters)
// on pulled-up buses, checked against a run-length reference model.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic [15:0] tb_data;
    logic        tb_drv;
    tri1  [15:0] dq1, dq3;
    logic [15:0] wr1, rd1;
    logic [3:0]  wr3, rd3;
    logic        cont1, cont3;

    always #5 clk = ~clk;

    assign dq1 = tb_drv ? tb_data : 16'hzzzz;
    assign dq3 = tb_drv ? tb_data : 16'hzzzz;

    sram_responder #(.DEPTH_LOG2(10), .READ_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .wr_count(wr1), .rd_count(rd1), .contention(cont1)
    );

    sram_responder #(.DEPTH_LOG2(10), .READ_LAT(3), .CNT_W(4)) u_lat3 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .wr_count(wr3), .rd_count(rd3), .contention(cont3)
    );

    // Reference model: a read is served once its address has been held for READ_LAT read edges
    logic [15:0] m_mem [1024];
    logic [17:0] m_addr;
    int          m_run, m_wr1, m_rd1, m_wr3, m_rd3;
    bit          m_cont;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_dq(input int lat);
        logic [15:0] d;
        logic [15:0] r;
        r = 16'hFFFF;
        if (!ce_n && we_n && !oe_n && m_run >= lat) begin
            d = m_mem[m_addr[9:0]];
            if (!ub_n) r[15:8] = d[15:8];
            if (!lb_n) r[7:0]  = d[7:0];
        end
        return r;
    endfunction

    task automatic model_edge();
        if (!ce_n && !we_n) begin
            if (!ub_n) m_mem[addr[9:0]][15:8] = tb_data[15:8];
            if (!lb_n) m_mem[addr[9:0]][7:0]  = tb_data[7:0];
            if (!ub_n || !lb_n) begin
                if (m_wr1 < 65535) m_wr1++;
                if (m_wr3 < 15) m_wr3++;
            end
            if (!oe_n) m_cont = 1'b1;
            m_run = 0;
        end else if (!ce_n && !oe_n) begin
            if (m_run > 0 && addr == m_addr) begin
                if (m_run < 64) m_run++;
            end else begin
                m_addr = addr;
                m_run  = 1;
            end
            if (m_run == 1 && m_rd1 < 65535) m_rd1++;
            if (m_run == 3 && m_rd3 < 15) m_rd3++;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic drive(input logic ce, we, oe, ub, lb, input logic [17:0] a, input logic [15:0] d);
        ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb;
        addr = a; tb_data = d; tb_drv = !we;
    endtask

    task automatic check_outputs();
        chk("wr_count_lat1", 32'(wr1), m_wr1);
        chk("rd_count_lat1", 32'(rd1), m_rd1);
        chk("wr_count_lat3", 32'(wr3), m_wr3);
        chk("rd_count_lat3", 32'(rd3), m_rd3);
        chk("contention_lat1", 32'(cont1), 32'(m_cont));
        chk("contention_lat3", 32'(cont3), 32'(m_cont));
    endtask

    // One clock: inputs applied at posedge+1, DQ checked before the edge, state after it
    task automatic cycle(input logic ce, we, oe, ub, lb, input logic [17:0] a, input logic [15:0] d);
        drive(ce, we, oe, ub, lb, a, d);
        #2;
        if (we_n) begin
            chk("dq_lat1", 32'(dq1), 32'(exp_dq(1)));
            chk("dq_lat3", 32'(dq3), 32'(exp_dq(3)));
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, lb);
        cycle(1'b0, 1'b0, 1'b1, ub, lb, a, d);
    endtask

    task automatic rd(input logic [17:0] a, input logic ub, lb, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0000);
    endtask

    initial begin
        int          pre;
        logic [17:0] ra;
        m_run = 0; m_wr1 = 0; m_rd1 = 0; m_wr3 = 0; m_rd3 = 0; m_cont = 1'b0; m_addr = '0;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
        #1;
        chk("reset_dq_lat1", 32'(dq1), 32'h0000FFFF);
        check_outputs();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Basic write then latency-1 read
        wr(18'h00012, 16'hA5C3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00012, '0);
        #2;
        chk("t1_hiz_first_edge", 32'(dq1), 32'h0000FFFF);
        rd(18'h00012, 1'b0, 1'b0, 1);
        chk("t1_data", 32'(dq1), 32'h0000A5C3);
        chk("t1_wr_count", 32'(wr1), 32'd1);
        chk("t1_rd_count", 32'(rd1), 32'd1);

        // Byte-masked write and masked read lanes
        wr(18'd5, 16'h1234, 1'b0, 1'b0);
        wr(18'd5, 16'hFF77, 1'b0, 1'b1);
        rd(18'd5, 1'b0, 1'b0, 1);
        chk("t2_merge_lat1", 32'(dq1), 32'h0000FF34);
        rd(18'd5, 1'b0, 1'b0, 2);
        chk("t2_merge_lat3", 32'(dq3), 32'h0000FF34);
        rd(18'd5, 1'b1, 1'b0, 1);
        rd(18'd5, 1'b0, 1'b1, 1);

        // Address change while waiting restarts the latency
        wr(18'd7, 16'h7070, 1'b0, 1'b0);
        wr(18'd8, 16'h0808, 1'b0, 1'b0);
        pre = m_rd3;
        rd(18'd7, 1'b0, 1'b0, 1);
        rd(18'd8, 1'b0, 1'b0, 1);
        chk("t3_wait1", 32'(dq3), 32'h0000FFFF);
        rd(18'd8, 1'b0, 1'b0, 1);
        chk("t3_wait2", 32'(dq3), 32'h0000FFFF);
        rd(18'd8, 1'b0, 1'b0, 1);
        chk("t3_data", 32'(dq3), 32'h00000808);
        chk("t3_rd_once", 32'(rd3), pre + 1);

        // Aliasing and fully-masked write
        wr(18'h00400, 16'hBEEF, 1'b0, 1'b0);
        rd(18'h00000, 1'b0, 1'b0, 1);
        chk("t4_alias", 32'(dq1), 32'h0000BEEF);
        pre = m_wr1;
        wr(18'h00400, 16'h1111, 1'b1, 1'b1);
        chk("t4_masked_no_count", 32'(wr1), pre);
        rd(18'h00000, 1'b0, 1'b0, 1);
        chk("t4_unchanged", 32'(dq1), 32'h0000BEEF);

        // Fill the array; also drives the 4-bit write counter into saturation
        for (int i = 0; i < 1024; i++) wr(18'(i), 16'($urandom), 1'b0, 1'b0);
        chk("wr3_saturated", 32'(wr3), 32'h0000000F);

        // WE and OE low together: flagged, and the write still lands
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00033, 16'hC0DE);
        chk("t5_contention", 32'(cont1), 32'd1);
        rd(18'h00033, 1'b0, 1'b0, 1);
        chk("t5_write_committed", 32'(dq1), 32'h0000C0DE);

        // Randomized traffic
        for (int b = 0; b < 400; b++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            ra = {(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00), 10'($urandom_range(0, 15))};
            if (kind == 0) begin
                wr(ra, 16'($urandom), 1'($urandom), 1'($urandom));
            end else if (kind == 3) begin
                cycle(1'($urandom), 1'b1, 1'b1, 1'($urandom), 1'($urandom), ra, '0);
            end else begin
                int n;
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 7) == 0) ra = 18'($urandom_range(0, 15));
                    rd(ra, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
                end
            end
        end

        // Asynchronous reset in the middle of a read
        rd(18'h00020, 1'b0, 1'b0, 3);
        chk("t6_driving_before_reset", 32'(dq1), 32'(m_mem[10'h020]));
        #2;
        rst = 1'b0;
        m_run = 0; m_wr1 = 0; m_rd1 = 0; m_wr3 = 0; m_rd3 = 0; m_cont = 1'b0;
        #1;
        chk("t6_dq_released_lat1", 32'(dq1), 32'h0000FFFF);
        chk("t6_dq_released_lat3", 32'(dq3), 32'h0000FFFF);
        check_outputs();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        rd(18'h00020, 1'b0, 1'b0, 3);
        chk("t6_array_intact", 32'(dq3), 32'(m_mem[10'h020]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
